fifo_burst_reader: RTL and testbench



---
 rtl/fifo_burst_reader.sv | 128 ++++++++++++
 tb/tb_fifo_burst_reader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Burst read controller for a level-sensitive FIFO. It streams bursts over a registered valid/ready port.
// Optional flush input is enabled by defining FIFO_BURST_READER_FLUSH_EN.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 64,
    parameter int BURST_W    = 8,
    parameter int TIMEOUT_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fifo_empty,
    input  logic [$clog2(FIFO_DEPTH):0] fifo_count,
    input  logic [DATA_WIDTH-1:0]       fifo_data,
    output logic                        fifo_drop,
    input  logic [BURST_W-1:0]          burst_len,
    input  logic [TIMEOUT_W-1:0]        timeout_cycles,
`ifdef FIFO_BURST_READER_FLUSH_EN
    input  logic                        flush,
`endif
    output logic [DATA_WIDTH-1:0]       m_data,
    output logic                        m_valid,
    output logic                        m_last,
    input  logic                        m_ready,
    output logic                        busy
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CMP_W = (CNT_W > BURST_W) ? CNT_W : BURST_W;

    typedef enum logic {S_WAIT, S_BURST} state_t;

    state_t                  state_q, state_d;
    logic [BURST_W-1:0]      remaining_q, remaining_d;
    logic [TIMEOUT_W-1:0]    tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
    logic                    m_valid_q, m_valid_d;
    logic                    m_last_q, m_last_d;

    logic [BURST_W-1:0]      burst_min;
    logic [BURST_W-1:0]      snapshot;
    logic [CMP_W-1:0]        count_ext;
    logic                    thresh_hit, tmo_hit, flush_hit, pop, xfer;

    always_comb begin
        burst_min  = (burst_len == '0) ? BURST_W'(1) : burst_len;
        count_ext  = CMP_W'(fifo_count);
        thresh_hit = count_ext >= CMP_W'(burst_min);
        // Timeout/flush snapshots saturate instead of wrapping to a short burst.
        if (count_ext > CMP_W'({BURST_W{1'b1}}))
            snapshot = {BURST_W{1'b1}};
        else
            snapshot = BURST_W'(count_ext);
        tmo_hit = (timeout_cycles != '0) && !fifo_empty
                  && (tmo_q == timeout_cycles - TIMEOUT_W'(1));
`ifdef FIFO_BURST_READER_FLUSH_EN
        flush_hit = flush && !fifo_empty;
`else
        flush_hit = 1'b0;
`endif
        // Gated by rst so a reset mid-burst consumes nothing further.
        pop  = (state_q == S_BURST) && (remaining_q != '0) && !fifo_empty
               && (!m_valid_q || m_ready) && !rst;
        xfer = m_valid_q && m_ready;
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        tmo_d       = tmo_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;

        case (state_q)
            S_WAIT: begin
                if (thresh_hit) begin
                    state_d     = S_BURST;
                    remaining_d = burst_min;
                    tmo_d       = '0;
                end else if (flush_hit || tmo_hit) begin
                    state_d     = S_BURST;
                    remaining_d = snapshot;
                    tmo_d       = '0;
                end else begin
                    tmo_d = fifo_empty ? '0 : tmo_q + TIMEOUT_W'(1);
                end
            end
            S_BURST: begin
                if (xfer && m_last_q)
                    state_d = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase

        if (pop) begin
            m_data_d    = fifo_data;
            m_valid_d   = 1'b1;
            m_last_d    = (remaining_q == BURST_W'(1));
            remaining_d = remaining_q - BURST_W'(1);
        end else if (xfer) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_WAIT;
            remaining_q <= '0;
            tmo_q       <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            tmo_q       <= tmo_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
        end
    end

    assign fifo_drop = pop;
    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign busy      = (state_q == S_BURST);
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO, scoreboard of pushed entries, negedge monitor.
module tb_fifo_burst_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [6:0]  fifo_count = '0;
    logic [31:0] fifo_data = '0;
    logic        fifo_drop;
    logic [7:0]  burst_len = 8'd4;
    logic [15:0] timeout_cycles = '0;
    logic [31:0] m_data;
    logic        m_valid, m_last, busy;
    logic        m_ready = 1'b1;
`ifdef FIFO_BURST_READER_FLUSH_EN
    logic        flush = 1'b0;
`endif

    fifo_burst_reader dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
        .fifo_data(fifo_data), .fifo_drop(fifo_drop), .burst_len(burst_len),
        .timeout_cycles(timeout_cycles),
`ifdef FIFO_BURST_READER_FLUSH_EN
        .flush(flush),
`endif
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int compared = 0, mismatched = 0;
    logic [31:0] fq[$], pend_q[$], exp_q[$];
    int cyc = 0;
    int drop_cyc[$];
    int xfer_cnt = 0, first_valid = -1, beat_in_burst = 0, exp_burst = 4;
    bit rand_ready = 0;
    logic        prev_stall = 0, prev_last = 0;
    logic [31:0] prev_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural FIFO: level drop consumes the head, pending pushes land on the same edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_drop && fq.size() > 0) fq.delete(0);
        while (pend_q.size() > 0) fq.push_back(pend_q.pop_front());
        fifo_empty <= (fq.size() == 0);
        fifo_count <= 7'(fq.size());
        fifo_data  <= (fq.size() > 0) ? fq[0] : 32'h0;
    end

    always @(negedge clk) begin
        if (rst) begin
            beat_in_burst = 0;
            prev_stall    = 0;
        end else begin
            if (fifo_drop) begin
                drop_cyc.push_back(cyc);
                chk("drop_while_empty", {31'b0, fifo_empty}, 32'd0);
                chk("drop_while_stalled", {31'b0, m_valid && !m_ready}, 32'd0);
            end
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (prev_stall) begin
                chk("hold_valid", {31'b0, m_valid}, 32'd1);
                chk("hold_data", m_data, prev_data);
                chk("hold_last", {31'b0, m_last}, {31'b0, prev_last});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_beat: got %h expected none", m_data);
                end else begin
                    chk("beat_data", m_data, exp_q.pop_front());
                end
                chk("beat_last", {31'b0, m_last}, {31'b0, beat_in_burst == exp_burst - 1});
                beat_in_burst = (beat_in_burst == exp_burst - 1) ? 0 : beat_in_burst + 1;
                xfer_cnt++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic push(input logic [31:0] v);
        pend_q.push_back(v);
        exp_q.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy || m_valid) && n < budget) begin
            if (rand_ready) m_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        m_ready = 1'b1;
        compared++;
        if (n >= budget) begin
            mismatched++;
            $display("FAIL drain_timeout: got %0d entries left expected 0", exp_q.size());
        end
        repeat (2) step();
    endtask

    initial begin
        int t0, base, n, len;
        logic [0:4] pat;

        // Reset state
        repeat (3) step();
        #4;
        chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("rst_m_last", {31'b0, m_last}, 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_drop", {31'b0, fifo_drop}, 32'd0);
        step();
        rst = 1'b0;
        step();

        // Full burst of 4 with continuous ready
        drop_cyc.delete();
        first_valid = -1;
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
        step();
        t0 = cyc;
        wait_idle(100);
        chk("t1_drops", 32'(drop_cyc.size()), 32'd4);
        if (drop_cyc.size() == 4) begin
            chk("t1_first_drop", 32'(drop_cyc[0]), 32'(t0 + 1));
            chk("t1_last_drop", 32'(drop_cyc[3]), 32'(t0 + 4));
        end
        chk("t1_latency", 32'(first_valid - t0), 32'd2);
        chk("t1_count", 32'(fifo_count), 32'd0);
        chk("t1_busy", {31'b0, busy}, 32'd0);

        // Partial burst released by the timeout
        timeout_cycles = 16'd10;
        exp_burst = 2;
        drop_cyc.delete();
        push(32'hB0);
        push(32'hB1);
        step();
        t0 = cyc;
        wait_idle(100);
        chk("t2_drops", 32'(drop_cyc.size()), 32'd2);
        if (drop_cyc.size() == 2) begin
            chk("t2_first_drop", 32'(drop_cyc[0]), 32'(t0 + 10));
            chk("t2_second_drop", 32'(drop_cyc[1]), 32'(t0 + 11));
        end
        timeout_cycles = '0;

        // Backpressure pattern
        burst_len = 8'd3;
        exp_burst = 3;
        base = xfer_cnt;
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(32'hC0 + 32'(i));
        n = 0;
        while (!m_valid && n < 50) begin step(); n++; end
        pat = 5'b10011;
        for (int i = 0; i < 5; i++) begin
            m_ready = pat[i];
            step();
        end
        wait_idle(100);
        chk("t3_beats", 32'(xfer_cnt - base), 32'd3);

        // Reset mid-burst
        burst_len = 8'd8;
        exp_burst = 8;
        base = xfer_cnt;
        for (int i = 0; i < 8; i++) push(32'hD0 + 32'(i));
        n = 0;
        while (xfer_cnt < base + 3 && n < 100) begin step(); n++; end
        rst = 1'b1;
        #4;
        chk("t4_drop_in_rst", {31'b0, fifo_drop}, 32'd0);
        step();
        chk("t4_m_valid", {31'b0, m_valid}, 32'd0);
        chk("t4_busy", {31'b0, busy}, 32'd0);
        chk("t4_count", 32'(fifo_count), 32'd4);
        step();
        chk("t4_count_held", 32'(fifo_count), 32'd4);
        exp_q = fq;
        burst_len = 8'd4;
        exp_burst = 4;
        rst = 1'b0;
        wait_idle(100);

        // burst_len of zero behaves as one
        burst_len = 8'd0;
        exp_burst = 1;
        drop_cyc.delete();
        push(32'hE0);
        push(32'hE1);
        wait_idle(100);
        chk("t5_drops", 32'(drop_cyc.size()), 32'd2);
        if (drop_cyc.size() == 2)
            chk("t5_gap", 32'(drop_cyc[1] - drop_cyc[0]), 32'd3);

`ifdef FIFO_BURST_READER_FLUSH_EN
        burst_len = 8'd16;
        exp_burst = 5;
        drop_cyc.delete();
        for (int i = 0; i < 5; i++) push(32'hF0 + 32'(i));
        repeat (20) step();
        chk("t6_no_drop", 32'(drop_cyc.size()), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_idle(100);
        chk("t6_drops", 32'(drop_cyc.size()), 32'd5);
`endif

        // Randomised traffic with random backpressure
        rand_ready = 1;
        for (int r = 0; r < 4; r++) begin
            len = $urandom_range(0, 5);
            burst_len = 8'(len);
            exp_burst = (len == 0) ? 1 : len;
            base = xfer_cnt;
            n = exp_burst * $urandom_range(2, 5);
            for (int i = 0; i < n; ) begin
                if ($urandom_range(0, 1) == 1) begin
                    push($urandom);
                    i++;
                end
                m_ready = 1'($urandom_range(0, 1));
                step();
            end
            wait_idle(400);
            chk("rand_beats", 32'(xfer_cnt - base), 32'(n));
        end
        rand_ready = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
